// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel word handshake in, serial bit stream out
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_last;
    logic             busy;

    modport master (
        output s_valid, s_data,
        input  s_ready, bit_out, bit_valid, bit_last, busy
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, bit_out, bit_valid, bit_last, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: shifts accepted parallel words out one bit per clock
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    bit_serializer_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_last_q, bit_last_d;
    logic             busy_q, busy_d;
    logic             at_last;
    logic             s_ready;
    logic             hs;

    // s_ready looks only at state and counter so a new word can land on the last bit
    assign at_last       = (state_q == SHIFT) && (cnt_q == LAST);
    assign s_ready       = (state_q == IDLE) || at_last;
    assign hs            = bus.s_valid && s_ready;
    assign bus.s_ready   = s_ready;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_last  = bit_last_q;
    assign bus.busy      = busy_q;

    // state, counter, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_last_q  <= bit_last_d;
            busy_q      <= busy_d;
        end
    end

    // a handshake always (re)enters SHIFT; the last bit without one drops to IDLE
    always_comb begin
        state_d = hs ? SHIFT : (at_last ? IDLE : state_q);
    end

    // present the first bit straight from s_data, later bits from the remaining word
    always_comb begin
        cnt_d       = '0;
        shreg_d     = '0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        bit_last_d  = 1'b0;
        busy_d      = 1'b0;
        if (hs) begin
            shreg_d     = MSB_FIRST ? bus.s_data << 1 : bus.s_data >> 1;
            bit_out_d   = MSB_FIRST ? bus.s_data[WIDTH-1] : bus.s_data[0];
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
        end else if (state_q == SHIFT && !at_last) begin
            cnt_d       = cnt_q + 1'b1;
            shreg_d     = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
            bit_out_d   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            bit_valid_d = 1'b1;
            bit_last_d  = (cnt_d == LAST);
            busy_d      = 1'b1;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: random and directed checks against a bit-queue reference model
module tb_bit_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  q[$];
    logic [31:0] cap;
    int          cap_n;
    logic [3:0]  hist;
    logic [31:0] hits;

    bit_serializer_if #(.WIDTH(8)) a ();
    bit_serializer_if #(.WIDTH(4)) b ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (.clk(clk), .reset(reset), .bus(a.slave));
    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4 (.clk(clk), .reset(reset), .bus(b.slave));

    always #5 clk = ~clk;

    task automatic clear();
        cap = '0;
        cap_n = 0;
        hist = '0;
        hits = '0;
    endtask

    task automatic push_word(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) q.push_back({1'(i == 0), d[i]});
    endtask

    task automatic step8(input logic v, input logic [7:0] d);
        logic ev, eb, el, er;
        @(negedge clk);
        ev = q.size() > 0;
        eb = ev ? q[0][0] : 1'b0;
        el = ev ? q[0][1] : 1'b0;
        er = q.size() <= 1;
        checks += 4;
        if ({a.bit_valid, a.busy} !== {ev, ev}) begin
            errors++;
            $display("FAIL valid_busy t=%0t got %b%b exp %b%b", $time, a.bit_valid, a.busy, ev, ev);
        end
        if (a.bit_out !== eb) begin
            errors++;
            $display("FAIL bit_out t=%0t got %b exp %b", $time, a.bit_out, eb);
        end
        if (a.bit_last !== el) begin
            errors++;
            $display("FAIL bit_last t=%0t got %b exp %b", $time, a.bit_last, el);
        end
        if (a.s_ready !== er) begin
            errors++;
            $display("FAIL s_ready t=%0t got %b exp %b", $time, a.s_ready, er);
        end
        if (a.bit_valid === 1'b1) begin
            cap = {cap[30:0], a.bit_out};
            cap_n++;
            hist = {hist[2:0], a.bit_out};
            if (hist == 4'b1101 && cap_n < 32) hits[cap_n] = 1'b1;
        end
        if (ev) void'(q.pop_front());
        if (v && er) push_word(d);
        a.s_valid = v;
        a.s_data = d;
    endtask

    task automatic check_word(input string name, input int n, input logic [31:0] exp);
        checks++;
        if (cap_n !== n || cap !== exp) begin
            errors++;
            $display("FAIL %s got %0d bits %h exp %0d bits %h", name, cap_n, cap, n, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 2;
        if ({a.bit_out, a.bit_valid, a.bit_last, a.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {a.bit_out, a.bit_valid, a.bit_last, a.busy});
        end
        if (a.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", a.s_ready);
        end
        clear();
        a.s_valid = 1'b1;
        a.s_data = 8'h96;
        push_word(8'h96);
        #1 reset = 1'b0;
        repeat (9) step8(1'b0, 8'h00);
        check_word("first_edge", 8, 32'h96);
    endtask

    task automatic test_single();
        clear();
        step8(1'b1, 8'hD0);
        repeat (9) step8(1'b0, 8'h00);
        check_word("single_d0", 8, 32'hD0);
    endtask

    task automatic test_back_to_back();
        clear();
        step8(1'b1, 8'hDD);
        repeat (8) step8(1'b1, 8'hB0);
        repeat (9) step8(1'b0, 8'h00);
        check_word("back_to_back", 16, 32'hDDB0);
    endtask

    task automatic test_hold_off();
        logic [7:0] w0, w1;
        clear();
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        step8(1'b1, w0);
        repeat (7) step8(1'b1, 8'($urandom));
        step8(1'b1, w1);
        repeat (9) step8(1'b0, 8'h00);
        check_word("hold_off", 16, {16'h0, w0, w1});
    endtask

    task automatic test_reset_mid();
        clear();
        step8(1'b1, 8'hFF);
        repeat (3) step8(1'b0, 8'h00);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 2;
        if ({a.bit_out, a.bit_valid, a.bit_last, a.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b exp 0000", {a.bit_out, a.bit_valid, a.bit_last, a.busy});
        end
        if (a.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %b exp 1", a.s_ready);
        end
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step8(1'b0, 8'h00);
        clear();
        step8(1'b1, 8'h0F);
        repeat (9) step8(1'b0, 8'h00);
        check_word("after_reset", 8, 32'h0F);
    endtask

    task automatic test_random();
        clear();
        repeat (400) step8($urandom_range(0, 3) != 0, 8'($urandom));
        repeat (10) step8(1'b0, 8'h00);
    endtask

    task automatic test_lsb4();
        logic [3:0] w;
        w = 4'b1011;
        @(negedge clk);
        checks++;
        if (b.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL lsb4_ready got %b exp 1", b.s_ready);
        end
        b.s_valid = 1'b1;
        b.s_data = w;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b.s_valid = 1'b0;
            b.s_data = 4'h0;
            checks++;
            if ({b.bit_valid, b.bit_out, b.bit_last} !== {1'b1, w[i], 1'(i == 3)}) begin
                errors++;
                $display("FAIL lsb4_bit%0d got v%b o%b l%b exp v1 o%b l%b", i, b.bit_valid, b.bit_out, b.bit_last, w[i], i == 3);
            end
        end
        @(negedge clk);
        checks++;
        if ({b.bit_valid, b.bit_out, b.bit_last, b.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL lsb4_idle got %b exp 0000", {b.bit_valid, b.bit_out, b.bit_last, b.busy});
        end
    endtask

    task automatic test_detector();
        clear();
        step8(1'b1, 8'hDA);
        repeat (9) step8(1'b0, 8'h00);
        checks++;
        if (hits !== 32'h90) begin
            errors++;
            $display("FAIL detector_hits got %h exp 00000090", hits);
        end
    endtask

    initial begin
        a.s_valid = 1'b0;
        a.s_data = 8'h00;
        b.s_valid = 1'b0;
        b.s_data = 4'h0;
        clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_off();
        test_reset_mid();
        test_random();
        test_lsb4();
        test_detector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
